ctrl_dly_prog: RTL and testbench
================================

// Module: ctrl_dly_prog
// PURPOSE
//   Multi-channel control/data delay line with per-channel valid tracking.
//   Delay is run-time programmable (0..MAX_DLY), with pipeline advance enable (stall) and flush.
//   Successor to the fixed-depth control delay used to align side-band control with datapath pipes.
//   Sits between packet-parse/checksum stages that need run-time re-alignment.
// PARAMETERS
//   DWID     10  data bits per channel
//   CH       1   number of channels; all channels share one programmed delay
//   MAX_DLY  8   maximum delay in cycles (>=1); sets physical stage count
//   DATA_RST 1   1: stage data cleared on reset/flush; 0: only valid bits cleared (SRL-friendly)
//   SELW     $clog2(MAX_DLY+1)  width of delay select (derived, not overridden)
// PORTS
//   clk       in   1         clock
//   rst_n     in   1         synchronous reset, active low
//   en        in   1         1: pipeline advances this cycle; 0: all stages hold
//   flush     in   1         clear all in-flight valids
//   din       in   CH*DWID   channel c at [c*DWID +: DWID]
//   din_vld   in   CH        per-channel input valid
//   cfg_wr    in   1         load cfg_dly as new active delay
//   cfg_dly   in   SELW      requested delay; values >MAX_DLY clamp to MAX_DLY
//   dout      out  CH*DWID   delayed data
//   dout_vld  out  CH        delayed per-channel valid
//   cur_dly   out  SELW      active delay
//   cfg_busy  out  1         1 while line refills after a delay change
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): cur_dly<=MAX_DLY, all stage valids<=0, settle counter<=0.
//     Stage data<=0 when DATA_RST=1. Post-reset outputs: dout_vld=0, cfg_busy=0, dout=0 (DATA_RST=1).
//   Storage: stages S[1..MAX_DLY], each CH*(DWID+1) bits (data+valid). S[0]={din,din_vld}.
//   Advance (en=1, flush=0): S[k]<=S[k-1] for k=1..MAX_DLY. en=0: every stage holds.
//   Output: {dout,dout_vld} = S[cur_dly], mux from registers.
//     cur_dly=0: combinational passthrough of din/din_vld, regardless of en.
//   Latency: with en held 1, input sampled at edge t appears at dout after edge t+cur_dly-1,
//     i.e. valid for exactly cur_dly cycles of delay. Stall cycles add 1:1 to latency.
//   Flush (flush=1): all stage valid bits<=0 (data too if DATA_RST=1); din this cycle dropped.
//     Overrides en. dout_vld=0 next cycle unless cur_dly=0, which stays passthrough.
//   Config FSM: two states, RUN and SETTLE.
//     RUN: cfg_wr=1 -> cur_dly<=clamp(cfg_dly); all stage valids cleared (implicit flush);
//       settle counter<=clamp(cfg_dly). Next state SETTLE if value !=0, else RUN.
//     SETTLE: cfg_busy=1. Counter decrements only on en=1 cycles; at 1->0 -> RUN.
//       cfg_wr in SETTLE restarts the sequence with the new value.
//       flush in SETTLE clears valids; counter unaffected.
//     cfg_busy is a registered output, 0 in RUN.
//   Simultaneous events:
//     cfg_wr+flush: single clear; config applied.
//     cfg_wr+en: din of that cycle is NOT captured (cleared with the line).
//   Clamp: cfg_dly>MAX_DLY loads MAX_DLY; cur_dly and cfg_busy reflect the clamped value.
//   Reset mid-operation: all in-flight data lost. Delay returns to MAX_DLY and FSM to RUN next cycle.
//   Channels are independent in valid only: a zero din_vld[c] propagates as a hole in lane c.
// TESTING
//   1 Reset, en=1, cur_dly=8, CH=2: drive din_vld=2'b11, incrementing data 1..20
//     -> first dout_vld=11 exactly 8 cycles later, dout sequence 1..20 in order, no gaps.
//   2 cfg_wr with cfg_dly=3 while streaming
//     -> dout_vld=0 next cycle, cfg_busy=1 for 3 en cycles, then data reappears with 3-cycle latency.
//   3 cfg_dly=0 -> dout==din and dout_vld==din_vld in the same cycle, including while en=0;
//     cfg_busy never asserts.
//   4 cur_dly=4, toggle en 1,0,0,1,... -> data order preserved; latency = 4 + stall count;
//     cfg_busy countdown frozen during stalls.
//   5 flush asserted 1 cycle mid-stream at cur_dly=5
//     -> exactly 5 output slots show dout_vld=0; stream then resumes with the post-flush input.
//   6 cfg_dly=15 with MAX_DLY=8 -> cur_dly=8; cfg_wr+flush together, and rst_n=0 mid-SETTLE
//     -> cur_dly=8, cfg_busy=0, dout_vld=0.

Source files
------------

// File: rtl/ctrl_dly_prog_if.sv
// Bus bundle for ctrl_dly_prog: stream in/out, pipeline controls and delay configuration.
// The master drives stream and configuration. The slave (the delay line) returns delayed data and status.
interface ctrl_dly_prog_if #(
  parameter int DWID    = 10,
  parameter int CH      = 1,
  parameter int MAX_DLY = 8
);
  localparam int SELW = $clog2(MAX_DLY + 1);

  logic                 en;
  logic                 flush;
  logic [CH*DWID-1:0]   din;
  logic [CH-1:0]        din_vld;
  logic                 cfg_wr;
  logic [SELW-1:0]      cfg_dly;
  logic [CH*DWID-1:0]   dout;
  logic [CH-1:0]        dout_vld;
  logic [SELW-1:0]      cur_dly;
  logic                 cfg_busy;

  modport master (
    output en, flush, din, din_vld, cfg_wr, cfg_dly,
    input  dout, dout_vld, cur_dly, cfg_busy
  );

  modport slave (
    input  en, flush, din, din_vld, cfg_wr, cfg_dly,
    output dout, dout_vld, cur_dly, cfg_busy
  );
endinterface

// File: rtl/ctrl_dly_prog.sv
// Multi-channel delay line with a run-time programmable depth (0..MAX_DLY), stall and flush.
// A delay change empties the line, and cfg_busy stays high until the line has refilled to the new depth.
module ctrl_dly_prog #(
  parameter int DWID     = 10,
  parameter int CH       = 1,
  parameter int MAX_DLY  = 8,
  parameter int DATA_RST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ctrl_dly_prog_if.slave  bus
);
  localparam int SELW = $clog2(MAX_DLY + 1);
  localparam int W    = CH * DWID;
  localparam logic [SELW-1:0] MAX_SEL = SELW'(MAX_DLY);

  typedef enum logic {RUN, SETTLE} state_t;

  state_t          state_reg, state_next;
  logic [SELW-1:0] cnt_reg, cnt_next;
  logic [SELW-1:0] cur_dly_reg, cur_dly_next;
  logic            busy_reg, busy_next;
  logic [SELW-1:0] cfg_clamp;
  logic            clr;

  logic [W-1:0]    data_reg [1:MAX_DLY];
  logic [CH-1:0]   vld_reg  [1:MAX_DLY];

  assign cfg_clamp = (bus.cfg_dly > MAX_SEL) ? MAX_SEL : bus.cfg_dly;
  // A delay change empties the line. The input word of that cycle is discarded with it.
  assign clr       = bus.flush | bus.cfg_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      cur_dly_reg <= MAX_SEL;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cur_dly_reg <= cur_dly_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cur_dly_next = cur_dly_reg;
    if (bus.cfg_wr) begin
      cur_dly_next = cfg_clamp;
      cnt_next     = cfg_clamp;
      state_next   = (cfg_clamp != '0) ? SETTLE : RUN;
    end else begin
      case (state_reg)
        RUN: ;
        SETTLE: begin
          // Only advancing cycles refill the line, so stalls freeze the countdown.
          if (bus.en) begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == SELW'(1))
              state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
    busy_next = (state_next == SETTLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int k = 1; k <= MAX_DLY; k++)
        vld_reg[k] <= '0;
    end else if (bus.en) begin
      vld_reg[1] <= bus.din_vld;
      for (int k = 2; k <= MAX_DLY; k++)
        vld_reg[k] <= vld_reg[k-1];
    end
  end

  generate
    if (DATA_RST != 0) begin : g_data_rst
      always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
          for (int k = 1; k <= MAX_DLY; k++)
            data_reg[k] <= '0;
        end else if (bus.en) begin
          data_reg[1] <= bus.din;
          for (int k = 2; k <= MAX_DLY; k++)
            data_reg[k] <= data_reg[k-1];
        end
      end
    end else begin : g_data_srl
      // Without a reset the data path has only a clock enable, so it can map to shift-register primitives.
      always_ff @(posedge clk) begin
        if (bus.en) begin
          data_reg[1] <= bus.din;
          for (int k = 2; k <= MAX_DLY; k++)
            data_reg[k] <= data_reg[k-1];
        end
      end
    end
  endgenerate

  always_comb begin
    bus.dout     = bus.din;
    bus.dout_vld = bus.din_vld;
    for (int k = 1; k <= MAX_DLY; k++) begin
      if (cur_dly_reg == SELW'(k)) begin
        bus.dout     = data_reg[k];
        bus.dout_vld = vld_reg[k];
      end
    end
  end

  assign bus.cur_dly  = cur_dly_reg;
  assign bus.cfg_busy = busy_reg;
endmodule

// File: tb/tb_ctrl_dly_prog.sv
// Self-checking bench for ctrl_dly_prog (CH=2, MAX_DLY=8, DATA_RST=1) against a queue-based reference model.
// Directed scenarios are followed by a randomized mix of stalls, flushes, delay changes and resets.
module tb_ctrl_dly_prog;
  localparam int DWID    = 10;
  localparam int CH      = 2;
  localparam int MAX_DLY = 8;
  localparam int W       = CH * DWID;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   known = 1'b0;

  // The reference line is a queue that holds the newest advanced word first. Tap n is the word from n advances ago.
  logic [W-1:0]  m_data[$];
  logic [CH-1:0] m_vld[$];
  int            m_cur  = MAX_DLY;
  int            m_left = 0;

  ctrl_dly_prog_if #(.DWID(DWID), .CH(CH), .MAX_DLY(MAX_DLY)) bus();

  ctrl_dly_prog #(.DWID(DWID), .CH(CH), .MAX_DLY(MAX_DLY), .DATA_RST(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic line_clear();
    m_data.delete();
    m_vld.delete();
    for (int k = 0; k < MAX_DLY; k++) begin
      m_data.push_back('0);
      m_vld.push_back('0);
    end
  endtask

  task automatic check();
    logic [W-1:0]  ed;
    logic [CH-1:0] ev;
    logic [3:0]    ec;
    logic          eb;
    if (m_cur == 0) begin
      ed = bus.din;
      ev = bus.din_vld;
    end else begin
      ed = m_data[m_cur-1];
      ev = m_vld[m_cur-1];
    end
    ec = 4'(m_cur);
    eb = (m_left > 0);
    checks += 4;
    assert (bus.dout === ed) else begin
      errors++;
      $error("FAIL dout obs=%h exp=%h", bus.dout, ed);
    end
    assert (bus.dout_vld === ev) else begin
      errors++;
      $error("FAIL dout_vld obs=%b exp=%b", bus.dout_vld, ev);
    end
    assert (bus.cur_dly === ec) else begin
      errors++;
      $error("FAIL cur_dly obs=%0d exp=%0d", bus.cur_dly, ec);
    end
    assert (bus.cfg_busy === eb) else begin
      errors++;
      $error("FAIL cfg_busy obs=%b exp=%b", bus.cfg_busy, eb);
    end
  endtask

  // One clock: apply the inputs, check the outputs in mid-cycle, then advance the model at the edge.
  task automatic tick(input logic r, input logic e, input logic f, input logic w,
                      input logic [3:0] d, input logic [CH-1:0] v, input logic [W-1:0] x);
    @(negedge clk);
    rst_n       = r;
    bus.en      = e;
    bus.flush   = f;
    bus.cfg_wr  = w;
    bus.cfg_dly = d;
    bus.din_vld = v;
    bus.din     = x;
    #1;
    if (known) check();
    $display("t=%0t rst_n=%b en=%b flush=%b cfg_wr=%b cfg_dly=%0d din=%h din_vld=%b | dout=%h dout_vld=%b cur_dly=%0d busy=%b",
             $time, r, e, f, w, d, x, v, bus.dout, bus.dout_vld, bus.cur_dly, bus.cfg_busy);
    @(posedge clk);
    if (!r) begin
      line_clear();
      m_cur  = MAX_DLY;
      m_left = 0;
      known  = 1'b1;
    end else begin
      if (w) begin
        m_cur  = (d > MAX_DLY) ? MAX_DLY : int'(d);
        m_left = m_cur;
      end else if (e && m_left > 0) begin
        m_left--;
      end
      if (f || w) begin
        line_clear();
      end else if (e) begin
        m_data.push_front(x);
        m_vld.push_front(v);
        void'(m_data.pop_back());
        void'(m_vld.pop_back());
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.flush = 1'b0; bus.cfg_wr = 1'b0;
    bus.cfg_dly = '0; bus.din = '0; bus.din_vld = '0;

    // Reset, then stream incrementing data at the default depth of 8.
    tick(0, 0, 0, 0, 0, 2'b00, '0);
    tick(0, 1, 0, 0, 0, 2'b00, '0);
    for (int i = 1; i <= 20; i++)
      tick(1, 1, 0, 0, 0, 2'b11, {10'(i), 10'(i)});
    for (int i = 21; i <= 30; i++)
      tick(1, 1, 0, 0, 0, 2'b11, {10'(i), 10'(i)});

    // Change the depth to 3 in the middle of a stream.
    tick(1, 1, 0, 1, 4'd3, 2'b11, {10'd31, 10'd31});
    for (int i = 32; i <= 45; i++)
      tick(1, 1, 0, 0, 0, 2'b11, {10'(i), 10'(i)});

    // Set the depth to 0: the line becomes a combinational passthrough, including during stalls.
    tick(1, 1, 0, 1, 4'd0, 2'b11, 20'($urandom));
    for (int i = 0; i < 20; i++)
      tick(1, 1'($urandom), 0, 0, 0, 2'($urandom), 20'($urandom));

    // At depth 4, use an en pattern of 1,0,0,... so stalls occur during refill and streaming.
    tick(1, 1, 0, 1, 4'd4, 2'b11, 20'($urandom));
    for (int i = 0; i < 30; i++)
      tick(1, (i % 3) == 0, 0, 0, 0, 2'($urandom), 20'($urandom));

    // At depth 5, assert flush for one cycle in the middle of a stream.
    tick(1, 1, 0, 1, 4'd5, 2'b11, 20'($urandom));
    for (int i = 0; i < 10; i++)
      tick(1, 1, 0, 0, 0, 2'b11, 20'($urandom));
    tick(1, 1, 1, 0, 0, 2'b11, 20'($urandom));
    for (int i = 0; i < 10; i++)
      tick(1, 1, 0, 0, 0, 2'b11, 20'($urandom));

    // Clamp a request of 15 to 8. Apply cfg_wr together with flush. Then reset while the line is settling.
    tick(1, 1, 0, 1, 4'd15, 2'b11, 20'($urandom));
    for (int i = 0; i < 3; i++)
      tick(1, 1, 0, 0, 0, 2'b11, 20'($urandom));
    tick(1, 1, 1, 1, 4'd6, 2'b11, 20'($urandom));
    for (int i = 0; i < 2; i++)
      tick(1, 1, 0, 0, 0, 2'b11, 20'($urandom));
    tick(0, 1, 0, 0, 0, 2'b11, 20'($urandom));
    for (int i = 0; i < 10; i++)
      tick(1, 1, 0, 0, 0, 2'($urandom), 20'($urandom));

    // Randomized mix of stalls, holes, flushes, delay changes and occasional resets.
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
           4'($urandom_range(0, 15)), 2'($urandom), 20'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
